// File: rtl/run_ctrl_pkg.sv
// Shared state encoding and default widths for the processor run controller.
package run_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_HALT = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10,
      ST_DONE = 2'b11
   } run_state_t;

   localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous board input, with a registered
// rising-edge detect on the synchronized level.
module sync_edge (
   input  logic clock,
   input  logic resetn,
   input  logic din,
   output logic level,
   output logic rise
);

   logic meta_p0;
   logic sync_p1;
   logic prev_p2;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         meta_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         prev_p2 <= 1'b0;
      end else begin
         meta_p0 <= din;
         sync_p1 <= meta_p0;
         prev_p2 <= sync_p1;
      end
   end

   assign level = sync_p1;
   assign rise  = sync_p1 & ~prev_p2;

endmodule

// File: rtl/run_controller.sv
// Execution controller: gates the multicycle datapath through cpu_en to give
// free-run, single-step, halt-request and PC-breakpoint modes, plus counters.
module run_controller
   import run_ctrl_pkg::*;
#(
   parameter int PC_W  = 8,
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             run_req,
   input  logic             step_req,
   input  logic             halt_req,
   input  logic             bp_en,
   input  logic [PC_W-1:0]  bp_addr,
   input  logic [PC_W-1:0]  pc,
   input  logic             ir_load,
   input  logic             stop,
   output logic             cpu_en,
   output logic [1:0]       state,
   output logic             bp_hit,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instr_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   run_state_t state_q;
   logic       first;
   logic       halt_pend;
   logic       bp_hit_q;
   logic       run_sync;
   logic       run_rise_unused;
   logic       step_sync_unused;
   logic       step_edge;
   logic       bp_match;
   logic       boundary;
   logic       pend_any;
   logic       running;
   logic       halt_now;

   sync_edge u_run_sync (
      .clock  (clock),
      .resetn (resetn),
      .din    (run_req),
      .level  (run_sync),
      .rise   (run_rise_unused)
   );

   sync_edge u_step_sync (
      .clock  (clock),
      .resetn (resetn),
      .din    (step_req),
      .level  (step_sync_unused),
      .rise   (step_edge)
   );

   // The first enabled cycle after leaving HALT never halts, so resuming on a
   // breakpointed PC still fetches that instruction.
   assign bp_match = bp_en & (pc == bp_addr);
   assign boundary = ir_load & ~first;
   assign pend_any = halt_pend | halt_req;
   assign running  = (state_q == ST_RUN) | (state_q == ST_STEP);

   always_comb begin
      halt_now = 1'b0;
      case (state_q)
         ST_RUN:  halt_now = boundary & (pend_any | ~run_sync | bp_match);
         ST_STEP: halt_now = boundary;
         default: halt_now = 1'b0;
      endcase
   end

   assign cpu_en = running & ~halt_now;
   assign state  = state_q;
   assign bp_hit = bp_hit_q;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_HALT;
         first     <= 1'b0;
         halt_pend <= 1'b0;
         bp_hit_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_HALT: begin
               if (run_sync) begin
                  state_q   <= ST_RUN;
                  first     <= 1'b1;
                  halt_pend <= 1'b0;
                  bp_hit_q  <= 1'b0;
               end else if (step_edge) begin
                  state_q   <= ST_STEP;
                  first     <= 1'b1;
                  halt_pend <= 1'b0;
                  bp_hit_q  <= 1'b0;
               end
            end
            ST_RUN, ST_STEP: begin
               if (cpu_en) first <= 1'b0;
               if (halt_req) halt_pend <= 1'b1;
               if (cpu_en & stop) begin
                  state_q <= ST_DONE;
               end else if (halt_now) begin
                  state_q <= ST_HALT;
                  if (bp_match) bp_hit_q <= 1'b1;
               end
            end
            ST_DONE: begin
            end
            default: state_q <= ST_HALT;
         endcase
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         cycle_count <= '0;
         instr_count <= '0;
      end else if (cpu_en) begin
         cycle_count <= sat_inc(cycle_count);
         if (ir_load) instr_count <= sat_inc(instr_count);
      end
   end

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: a 4-cycle-per-instruction processor stand-in
// driven by cpu_en, with expectations queued as stimulus is applied.
module tb_run_controller;
   import run_ctrl_pkg::*;

   localparam int PC_W  = 8;
   localparam int CNT_W = 16;

   logic             clock    = 1'b0;
   logic             resetn   = 1'b0;
   logic             run_req  = 1'b0;
   logic             step_req = 1'b0;
   logic             halt_req = 1'b0;
   logic             bp_en    = 1'b0;
   logic             stop     = 1'b0;
   logic [PC_W-1:0]  bp_addr  = '0;
   logic [PC_W-1:0]  pc_m;
   logic [1:0]       phase;
   logic             ir_load;
   logic             cpu_en;
   logic [1:0]       state;
   logic             bp_hit;
   logic [CNT_W-1:0] cycle_count;
   logic [CNT_W-1:0] instr_count;
   logic             cpu_en_s;
   logic [1:0]       state_s;
   logic             bp_hit_s;
   logic [3:0]       cyc_s;
   logic [3:0]       ins_s;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;
   exp_t sb[$];
   exp_t e;

   always #5 clock = ~clock;

   // Processor stand-in: fetch in phase 0 (pc advances), three more cycles.
   assign ir_load = (phase == 2'd0);
   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         phase <= 2'd0;
         pc_m  <= '0;
      end else if (cpu_en) begin
         phase <= phase + 2'd1;
         if (phase == 2'd0) pc_m <= pc_m + 8'd1;
      end
   end

   run_controller #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .clock(clock), .resetn(resetn), .run_req(run_req), .step_req(step_req),
      .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc_m),
      .ir_load(ir_load), .stop(stop), .cpu_en(cpu_en), .state(state),
      .bp_hit(bp_hit), .cycle_count(cycle_count), .instr_count(instr_count)
   );

   run_controller #(.PC_W(PC_W), .CNT_W(4)) dut_s (
      .clock(clock), .resetn(resetn), .run_req(run_req), .step_req(step_req),
      .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc_m),
      .ir_load(ir_load), .stop(stop), .cpu_en(cpu_en_s), .state(state_s),
      .bp_hit(bp_hit_s), .cycle_count(cyc_s), .instr_count(ins_s)
   );

   task automatic do_reset();
      resetn = 1'b0; run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0;
      bp_en = 1'b0; stop = 1'b0; bp_addr = '0;
      repeat (2) @(negedge clock);
      resetn = 1'b1;
   endtask

   task automatic wait_state(input logic [1:0] s, input int max);
      for (int i = 0; i < max && state !== s; i++) @(negedge clock);
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      sb.push_back('{name:"rst_state",  val:32'd0});
      sb.push_back('{name:"rst_cpu_en", val:32'd0});
      sb.push_back('{name:"rst_cycles", val:32'd0});
      sb.push_back('{name:"rst_instrs", val:32'd0});
      sb.push_back('{name:"rst_bp_hit", val:32'd0});
      repeat (2) @(negedge clock);
      e = sb.pop_front(); checks++;
      if (32'(state) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, state, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(cpu_en) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, cpu_en, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(cycle_count) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, cycle_count, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(instr_count) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, instr_count, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(bp_hit) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, bp_hit, e.val); end
      resetn = 1'b1;
      sb.push_back('{name:"idle_state",  val:32'd0});
      sb.push_back('{name:"idle_cpu_en", val:32'd0});
      repeat (4) @(negedge clock);
      e = sb.pop_front(); checks++;
      if (32'(state) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, state, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(cpu_en) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, cpu_en, e.val); end
   endtask

   task automatic test_run();
      do_reset();
      run_req = 1'b1;
      sb.push_back('{name:"run_lat2_state", val:32'd0});
      repeat (2) @(negedge clock);
      e = sb.pop_front(); checks++;
      if (32'(state) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, state, e.val); end
      sb.push_back('{name:"run_lat3_state", val:32'd1});
      sb.push_back('{name:"run_first_en",   val:32'd1});
      @(negedge clock);
      e = sb.pop_front(); checks++;
      if (32'(state) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, state, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(cpu_en) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, cpu_en, e.val); end
      sb.push_back('{name:"run_cycles", val:32'd10});
      sb.push_back('{name:"run_instrs", val:32'd3});
      repeat (10) @(negedge clock);
      e = sb.pop_front(); checks++;
      if (32'(cycle_count) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, cycle_count, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(instr_count) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, instr_count, e.val); end
      run_req = 1'b0;
      sb.push_back('{name:"run_off_state",  val:32'd0});
      sb.push_back('{name:"run_off_pc",     val:32'd3});
      sb.push_back('{name:"run_off_cycles", val:32'd12});
      sb.push_back('{name:"run_off_ir",     val:32'd1});
      wait_state(ST_HALT, 12);
      e = sb.pop_front(); checks++;
      if (32'(state) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, state, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(pc_m) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, pc_m, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(cycle_count) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, cycle_count, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(ir_load) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, ir_load, e.val); end
   endtask

   task automatic test_step();
      int n = 0;
      do_reset();
      step_req = 1'b1;
      sb.push_back('{name:"step_lat2_state", val:32'd0});
      repeat (2) @(negedge clock);
      e = sb.pop_front(); checks++;
      if (32'(state) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, state, e.val); end
      sb.push_back('{name:"step_lat3_state", val:32'd2});
      sb.push_back('{name:"step_first_en",   val:32'd1});
      @(negedge clock);
      e = sb.pop_front(); checks++;
      if (32'(state) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, state, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(cpu_en) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, cpu_en, e.val); end
      sb.push_back('{name:"step_en_cycles", val:32'd4});
      sb.push_back('{name:"step_state",     val:32'd0});
      sb.push_back('{name:"step_instrs",    val:32'd1});
      sb.push_back('{name:"step_cpu_en",    val:32'd0});
      for (int i = 0; i < 20 && state === 2'b10; i++) begin
         if (cpu_en === 1'b1) n++;
         @(negedge clock);
      end
      e = sb.pop_front(); checks++;
      if (n !== int'(e.val)) begin errors++; $display("FAIL %s: observed %0d expected %0d", e.name, n, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(state) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, state, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(instr_count) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, instr_count, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(cpu_en) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, cpu_en, e.val); end
      step_req = 1'b0;
      sb.push_back('{name:"step_release_state", val:32'd0});
      repeat (5) @(negedge clock);
      e = sb.pop_front(); checks++;
      if (32'(state) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, state, e.val); end
   endtask

   task automatic test_bp_run();
      do_reset();
      bp_en = 1'b1; bp_addr = 8'h02; run_req = 1'b1;
      sb.push_back('{name:"bp2_state",  val:32'd0});
      sb.push_back('{name:"bp2_pc",     val:32'd2});
      sb.push_back('{name:"bp2_hit",    val:32'd1});
      sb.push_back('{name:"bp2_cycles", val:32'd8});
      wait_state(ST_RUN, 6);
      wait_state(ST_HALT, 20);
      e = sb.pop_front(); checks++;
      if (32'(state) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, state, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(pc_m) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, pc_m, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(bp_hit) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, bp_hit, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(cycle_count) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, cycle_count, e.val); end
   endtask

   task automatic test_bp_step();
      do_reset();
      bp_en = 1'b1; bp_addr = 8'h05; run_req = 1'b1;
      wait_state(ST_RUN, 6);
      for (int i = 0; i < 40 && !(pc_m == 8'h05 && phase == 2'd1); i++) @(negedge clock);
      run_req = 1'b0;
      sb.push_back('{name:"bp5_state",  val:32'd0});
      sb.push_back('{name:"bp5_pc",     val:32'd5});
      sb.push_back('{name:"bp5_hit",    val:32'd1});
      sb.push_back('{name:"bp5_instrs", val:32'd5});
      wait_state(ST_HALT, 10);
      repeat (3) @(negedge clock);
      e = sb.pop_front(); checks++;
      if (32'(state) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, state, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(pc_m) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, pc_m, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(bp_hit) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, bp_hit, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(instr_count) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, instr_count, e.val); end
      step_req = 1'b1;
      sb.push_back('{name:"bp5_step_clr", val:32'd0});
      wait_state(ST_STEP, 6);
      e = sb.pop_front(); checks++;
      if (32'(bp_hit) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, bp_hit, e.val); end
      sb.push_back('{name:"bp5_step_pc",     val:32'd6});
      sb.push_back('{name:"bp5_step_hit",    val:32'd0});
      sb.push_back('{name:"bp5_step_instrs", val:32'd6});
      wait_state(ST_HALT, 10);
      e = sb.pop_front(); checks++;
      if (32'(pc_m) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, pc_m, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(bp_hit) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, bp_hit, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(instr_count) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, instr_count, e.val); end
      step_req = 1'b0;
   endtask

   task automatic test_halt_req();
      do_reset();
      run_req = 1'b1;
      wait_state(ST_RUN, 6);
      for (int i = 0; i < 20 && !(pc_m == 8'h02 && phase == 2'd1); i++) @(negedge clock);
      halt_req = 1'b1;
      @(negedge clock);
      halt_req = 1'b0;
      sb.push_back('{name:"hr_state", val:32'd0});
      sb.push_back('{name:"hr_pc",    val:32'd2});
      wait_state(ST_HALT, 8);
      e = sb.pop_front(); checks++;
      if (32'(state) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, state, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(pc_m) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, pc_m, e.val); end
      // run_req still high, so the controller resumes; pulse on a boundary next.
      wait_state(ST_RUN, 4);
      for (int i = 0; i < 20 && !(pc_m == 8'h03 && phase == 2'd0); i++) @(negedge clock);
      sb.push_back('{name:"hr_bnd_pre_en", val:32'd1});
      sb.push_back('{name:"hr_bnd_en",     val:32'd0});
      sb.push_back('{name:"hr_bnd_state",  val:32'd0});
      sb.push_back('{name:"hr_bnd_pc",     val:32'd3});
      e = sb.pop_front(); checks++;
      if (32'(cpu_en) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, cpu_en, e.val); end
      halt_req = 1'b1;
      #1;
      e = sb.pop_front(); checks++;
      if (32'(cpu_en) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, cpu_en, e.val); end
      @(negedge clock);
      halt_req = 1'b0;
      e = sb.pop_front(); checks++;
      if (32'(state) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, state, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(pc_m) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, pc_m, e.val); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      run_req = 1'b1; step_req = 1'b1;
      sb.push_back('{name:"race_state", val:32'd1});
      repeat (3) @(negedge clock);
      e = sb.pop_front(); checks++;
      if (32'(state) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, state, e.val); end
      run_req = 1'b0;
      sb.push_back('{name:"race_halted", val:32'd0});
      wait_state(ST_HALT, 12);
      repeat (6) @(negedge clock);
      e = sb.pop_front(); checks++;
      if (32'(state) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, state, e.val); end
      step_req = 1'b0;
   endtask

   task automatic test_stop();
      do_reset();
      run_req = 1'b1;
      wait_state(ST_RUN, 6);
      repeat (2) @(negedge clock);
      stop = 1'b1;
      @(negedge clock);
      stop = 1'b0;
      sb.push_back('{name:"stop_state",  val:32'd3});
      sb.push_back('{name:"stop_cpu_en", val:32'd0});
      e = sb.pop_front(); checks++;
      if (32'(state) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, state, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(cpu_en) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, cpu_en, e.val); end
      step_req = 1'b1; run_req = 1'b0;
      repeat (6) @(negedge clock);
      run_req = 1'b1; step_req = 1'b0;
      repeat (6) @(negedge clock);
      sb.push_back('{name:"done_state",  val:32'd3});
      sb.push_back('{name:"done_cpu_en", val:32'd0});
      sb.push_back('{name:"done_cycles", val:32'd3});
      sb.push_back('{name:"done_instrs", val:32'd1});
      e = sb.pop_front(); checks++;
      if (32'(state) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, state, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(cpu_en) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, cpu_en, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(cycle_count) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, cycle_count, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(instr_count) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, instr_count, e.val); end
   endtask

   task automatic test_saturation();
      do_reset();
      run_req = 1'b1;
      wait_state(ST_RUN, 6);
      sb.push_back('{name:"sat_cycles_16", val:32'd70});
      sb.push_back('{name:"sat_instrs_16", val:32'd18});
      sb.push_back('{name:"sat_cycles_4",  val:32'hF});
      sb.push_back('{name:"sat_instrs_4",  val:32'hF});
      repeat (70) @(negedge clock);
      e = sb.pop_front(); checks++;
      if (32'(cycle_count) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, cycle_count, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(instr_count) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, instr_count, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(cyc_s) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, cyc_s, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(ins_s) !== e.val) begin errors++; $display("FAIL %s: observed %0h expected %0h", e.name, ins_s, e.val); end
   endtask

   initial begin
      test_reset();
      test_run();
      test_step();
      test_bp_run();
      test_bp_step();
      test_halt_req();
      test_back_to_back();
      test_stop();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1);
   end

endmodule

// File: doc/run_controller.md
# run_controller

Execution controller for the multicycle processor. Sequences the datapath through a single clock-enable (`cpu_en`) that qualifies every state element of the datapath and its control FSM, giving free-run, single-instruction step, halt-on-request and PC-breakpoint modes. It sits between the board inputs (switches, step key) and the processor. It exports instruction and cycle counters for the hex-display muxes.

## Interface
Parameters:
- `PC_W`, 8, width of PC and breakpoint address
- `CNT_W`, 16, width of `cycle_count` and `instr_count`

Ports:
- `clock`  in  1  system clock
- `resetn`  in  1  asynchronous, active-low reset
- `run_req`  in  1  level, asynchronous (switch); request free-running execution
- `step_req`  in  1  level, asynchronous (pushbutton, active-high); a rising edge requests one instruction
- `halt_req`  in  1  synchronous pulse; halt at the next instruction boundary
- `bp_en`  in  1  breakpoint enable
- `bp_addr`  in  PC_W  breakpoint PC
- `pc`  in  PC_W  current PC register value
- `ir_load`  in  1  control-FSM IR load; high = fetch cycle = instruction boundary
- `stop`  in  1  processor Stop output
- `cpu_en`  out  1  datapath/FSM clock enable
- `state`  out  2  current mode: HALT=00, RUN=01, STEP=10, DONE=11
- `bp_hit`  out  1  sticky; last halt was caused by the breakpoint
- `cycle_count`  out  CNT_W  enabled cycles, saturating
- `instr_count`  out  CNT_W  fetched instructions, saturating

## Operation
- `run_req` and `step_req` pass through a 2-flop synchronizer. `step_req` then goes through an edge register; `step_edge` = sync & ~prev.
- Instruction boundary: a cycle with `ir_load`=1. All halts happen at a boundary, with `cpu_en`=0 that same cycle. The FSM then waits in fetch.
- `first` flag: set on every transition out of HALT; cleared after the first cycle with `cpu_en`=1. While `first`=1, the boundary halt checks are suppressed, so resuming on a breakpointed PC makes progress.
- HALT: `cpu_en`=0.
  - Synced `run_req`=1 -> RUN. This takes priority; a simultaneous `step_edge` is discarded.
  - Else `step_edge` -> STEP.
  - Leaving HALT clears `bp_hit` and `halt_pend`.
- RUN: `cpu_en`=1 except at a boundary with `first`=0 and any of: `halt_pend`, synced `run_req`=0, or (`bp_en` & `pc`==`bp_addr`). In that case `cpu_en`=0 and the next state is HALT. If the breakpoint term is true, `bp_hit` is set, even when another term is also true.
- STEP: same as RUN, except the halt condition is any boundary with `first`=0. The breakpoint still sets `bp_hit` if it matches.
- `halt_req` pulse in RUN/STEP sets `halt_pend`. In HALT/DONE it is ignored.
- `step_edge` in RUN/STEP/DONE is ignored.
- `stop`=1 while `cpu_en`=1 -> DONE. This takes priority over all halt conditions. In DONE, `cpu_en`=0 until reset; all requests are ignored.
- Counters (both saturate at all-ones, no wrap):
  - `cycle_count` += 1 on every cycle with `cpu_en`=1.
  - `instr_count` += 1 on every cycle with `cpu_en` & `ir_load`.

## Timing
- Reset (async assert, synchronous release by clock edge): `state`=HALT, `cpu_en`=0, `bp_hit`=0, both counters 0, synchronizers/edge register/`first`/`halt_pend` 0. Reset mid-instruction abandons it; the datapath is reset by the same signal.
- `cpu_en` is Moore-on-state plus combinational on `ir_load`, `pc`, `halt_pend`, `first`, and synced `run_req`. It must settle in the same cycle. No combinational path from `cpu_en` back to `ir_load` is permitted (FSM outputs depend on FSM state only).
- `step_req` rising before edge k -> `step_edge` high in cycle after k+1 -> `state`=STEP after edge k+2 -> `cpu_en`=1 from that cycle.
- `run_req` 0->1 -> RUN after 2 edges of sync latency plus 1 transition edge. `run_req` 1->0 -> halt at the next boundary after sync.
- `halt_req` is 1-cycle; a pulse coinciding with a boundary halts that same boundary (pend is OR-ed combinationally).

## Structure
- Package `run_ctrl_pkg`: 2-bit state encoding constants (HALT, RUN, STEP, DONE) and the default `CNT_W`.
- Sub-module `sync_edge`: 2-flop synchronizer plus registered rising-edge detect, async active-low clear. Instantiated for `step_req`; the level output is used for `run_req`.
- Remainder is one state register, flags, and two saturating counters.

## Test plan
- Reset with inputs idle -> `state`=00, `cpu_en`=0, counters 0. Hold `run_req`=1 -> RUN by edge 3; `cycle_count` tracks enabled cycles.
- HALT, one `step_req` press, FSM model with 4-cycle instructions -> exactly 4 `cpu_en` cycles, `instr_count`=1, `state` back to 00 with `ir_load`=1 held.
- RUN, `bp_en`=1, `bp_addr`=0x05 -> halt when `pc`=0x05 at fetch, `bp_hit`=1. A subsequent step executes the instruction at 0x05 and clears `bp_hit`.
- `halt_req` pulse mid-instruction in RUN -> completes the current instruction, halts at the next fetch. Simultaneous `run_req` rise + `step_req` edge in HALT -> RUN.
- `stop`=1 in RUN -> `state`=11, `cpu_en`=0, ignores `step_req`/`run_req`. Preload `cycle_count` near 0xFFFF (force) -> saturates at 0xFFFF.
